// File: rtl/i2c_slave_if.sv
// Byte-level handshake between the I2C slave and its host logic.
// The open-drain Sda pin stays a plain top-level port.
interface i2c_slave_if;
  logic       Scl;
  logic [7:0] TxData;
  logic       TxReq;
  logic [7:0] RxData;
  logic       RxValid;
  logic       Busy;
  logic [3:0] State;

  modport master (
    output Scl,
    output TxData,
    input  TxReq,
    input  RxData,
    input  RxValid,
    input  Busy,
    input  State
  );

  modport slave (
    input  Scl,
    input  TxData,
    output TxReq,
    output RxData,
    output RxValid,
    output Busy,
    output State
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C slave oversampled by Clk: LSB-first address/data, R/W=1 means master writes.
// Acks every written byte, streams TxData on reads, never stretches Scl.
module i2c_slave #(
  parameter int unsigned              ADDRESSLENGTH = 7,
  parameter logic [ADDRESSLENGTH-1:0] SLAVE_ADDR    = 7'h48
) (
  input  logic       Clk,
  input  logic       Rst,
  inout  wire        Sda,
  i2c_slave_if.slave bus
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ACNT_W   = $clog2(ADDRESSLENGTH + 1);
  localparam int unsigned CNT_W    = (ACNT_W > 4) ? ACNT_W : 4;
  localparam int unsigned LAST_BIT = DATA_W - 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_RX_DATA   = 4'd3,
    S_RX_ACK    = 4'd4,
    S_TX_DATA   = 4'd5,
    S_TX_ACK    = 4'd6,
    S_WAIT_STOP = 4'd7
  } state_t;

  state_t                   state;
  logic                     scl_s1, scl_s2, scl_d;
  logic                     sda_s1, sda_s2, sda_d;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DATA_W-1:0]        shifter;
  logic [ADDRESSLENGTH-1:0] addr_sh;
  logic                     rw;
  logic                     ack_phase;
  logic                     sda_low;
  logic [DATA_W-1:0]        rx_data;
  logic                     rx_pend;
  logic                     rx_valid;
  logic                     tx_req;
  logic                     busy;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Edges are taken between the synchronized copy and one more registered stage
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 & ~sda_d &  sda_s2;

  assign Sda         = sda_low ? 1'b0 : 1'bz;
  assign bus.TxReq   = tx_req;
  assign bus.RxData  = rx_data;
  assign bus.RxValid = rx_valid;
  assign bus.Busy    = busy;
  assign bus.State   = state;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_IDLE;
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_d     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_d     <= 1'b1;
      bit_cnt   <= '0;
      shifter   <= '0;
      addr_sh   <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_low   <= 1'b0;
      rx_data   <= '0;
      rx_pend   <= 1'b0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      scl_s1   <= bus.Scl;
      scl_s2   <= scl_s1;
      scl_d    <= scl_s2;
      sda_s1   <= Sda;
      sda_s2   <= sda_s1;
      sda_d    <= sda_s2;
      tx_req   <= 1'b0;
      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;

      // Bus conditions pre-empt any bit edge seen in the same cycle
      if (stop_det) begin
        state     <= S_IDLE;
        sda_low   <= 1'b0;
        busy      <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= '0;
        shifter   <= '0;
        addr_sh   <= '0;
        ack_phase <= 1'b0;
        sda_low   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sda_low <= 1'b0;
          end

          S_ADDR: begin
            if (scl_rise) begin
              if (bit_cnt == CNT_W'(ADDRESSLENGTH)) begin
                rw        <= sda_s2;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                if (addr_sh == SLAVE_ADDR) begin
                  state <= S_ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= S_WAIT_STOP;
                end
              end else begin
                addr_sh <= {sda_s2, addr_sh[ADDRESSLENGTH-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          // First falling edge starts the ack, second ends it and opens the data phase
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_low   <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                if (rw) begin
                  sda_low <= 1'b0;
                  shifter <= '0;
                  bit_cnt <= '0;
                  state   <= S_RX_DATA;
                end else begin
                  shifter <= bus.TxData;
                  tx_req  <= 1'b1;
                  sda_low <= ~bus.TxData[0];
                  bit_cnt <= CNT_W'(1);
                  state   <= S_TX_DATA;
                end
              end
            end
          end

          S_RX_DATA: begin
            if (scl_rise) begin
              shifter <= {sda_s2, shifter[DATA_W-1:1]};
              if (bit_cnt == CNT_W'(LAST_BIT)) begin
                rx_data   <= {sda_s2, shifter[DATA_W-1:1]};
                rx_pend   <= 1'b1;
                ack_phase <= 1'b0;
                state     <= S_RX_ACK;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          S_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_low   <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_low   <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                state     <= S_RX_DATA;
              end
            end
          end

          // bit_cnt counts bits already put on the bus; bit 0 went out on entry
          S_TX_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == CNT_W'(DATA_W)) begin
                sda_low   <= 1'b0;
                ack_phase <= 1'b0;
                state     <= S_TX_ACK;
              end else begin
                sda_low <= ~shifter[1];
                shifter <= {1'b0, shifter[DATA_W-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end

          S_TX_ACK: begin
            if (scl_rise && !ack_phase) begin
              if (sda_s2) begin
                state <= S_WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              shifter   <= bus.TxData;
              tx_req    <= 1'b1;
              sda_low   <= ~bus.TxData[0];
              bit_cnt   <= CNT_W'(1);
              state     <= S_TX_DATA;
            end
          end

          S_WAIT_STOP: begin
            sda_low <= 1'b0;
          end

          default: begin
            state   <= S_IDLE;
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench for i2c_slave: a bit-banged master plus a byte scoreboard.
module tb_i2c_slave;

  localparam int unsigned Q            = 4;
  localparam logic [6:0]  MY_ADDR      = 7'h48;
  localparam logic [6:0]  OTHER_ADDR   = 7'h21;
  localparam logic [3:0]  ST_IDLE      = 4'd0;
  localparam logic [3:0]  ST_ADDR      = 4'd1;
  localparam logic [3:0]  ST_WAIT_STOP = 4'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_low;
  wire        sda_line;
  int         vecs = 0;
  int         errs = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         slave_low_cnt = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] last_written = 8'h00;
  logic [7:0] exp_q[$];

  i2c_slave_if bus ();

  assign sda_line = m_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  i2c_slave #(.ADDRESSLENGTH(7), .SLAVE_ADDR(7'h48)) dut (
    .Clk (clk),
    .Rst (rst),
    .Sda (sda_line),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters and a record of any cycle where only the slave pulls Sda low
  always @(posedge clk) begin
    if (bus.RxValid) begin
      rx_cnt  <= rx_cnt + 1;
      last_rx <= bus.RxData;
    end
    if (bus.TxReq) tx_cnt <= tx_cnt + 1;
    if (sda_line === 1'b0 && !m_low) slave_low_cnt <= slave_low_cnt + 1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    m_low = 1'b0; wait_q();
    bus.Scl = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    bus.Scl = 1'b0; wait_q();
  endtask

  task automatic m_stop();
    m_low = 1'b1; wait_q();
    bus.Scl = 1'b1; wait_q();
    m_low = 1'b0; wait_q();
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_low = ~b; wait_q();
    bus.Scl = 1'b1; wait_q();
    r = sda_line; wait_q();
    bus.Scl = 1'b0; wait_q();
  endtask

  task automatic m_addr(input logic [6:0] a, input logic rw, output logic ack);
    logic r;
    for (int i = 0; i < 7; i++) m_bit(a[i], r);
    m_bit(rw, r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) m_bit(d[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read8(output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; m_low = 1'b0; bus.Scl = 1'b1; bus.TxData = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (bus.State !== ST_IDLE) begin errs++; $display("FAIL reset_state got %0d want %0d", bus.State, ST_IDLE); end
    vecs++; if (bus.RxData !== 8'h00) begin errs++; $display("FAIL reset_rxdata got %h want 00", bus.RxData); end
    vecs++; if (bus.RxValid !== 1'b0) begin errs++; $display("FAIL reset_rxvalid got %b want 0", bus.RxValid); end
    vecs++; if (bus.TxReq !== 1'b0) begin errs++; $display("FAIL reset_txreq got %b want 0", bus.TxReq); end
    vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    vecs++; if (sda_line !== 1'b1) begin errs++; $display("FAIL reset_sda got %b want 1", sda_line); end
    @(negedge clk); rst = 1'b1;
    wait_q();
  endtask

  task automatic test_write();
    logic ack; logic [7:0] e; int rx0;
    rx0 = rx_cnt;
    m_start();
    m_addr(MY_ADDR, 1'b1, ack);
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    vecs++; if (bus.Busy !== 1'b1) begin errs++; $display("FAIL wr_busy_set got %b want 1", bus.Busy); end
    exp_q.push_back(8'hA5);
    m_write_byte(8'hA5, ack);
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL wr_data_ack got %b want 0", ack); end
    vecs++; if (rx_cnt != rx0 + 1) begin errs++; $display("FAIL wr_rxvalid_cnt got %0d want %0d", rx_cnt - rx0, 1); end
    e = exp_q.pop_front();
    vecs++; if (last_rx !== e) begin errs++; $display("FAIL wr_rxdata got %h want %h", last_rx, e); end
    m_stop(); wait_q();
    vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL wr_busy_clr got %b want 0", bus.Busy); end
    vecs++; if (bus.State !== ST_IDLE) begin errs++; $display("FAIL wr_idle got %0d want %0d", bus.State, ST_IDLE); end
    last_written = 8'hA5;
  endtask

  task automatic test_read();
    logic ack, r; logic [7:0] d, e; int tx0;
    tx0 = tx_cnt;
    bus.TxData = 8'h3C; exp_q.push_back(8'h3C);
    m_start();
    m_addr(MY_ADDR, 1'b0, ack);
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL rd_addr_ack got %b want 0", ack); end
    m_read8(d);
    e = exp_q.pop_front();
    vecs++; if (d !== e) begin errs++; $display("FAIL rd_byte0 got %h want %h", d, e); end
    bus.TxData = 8'hC3; exp_q.push_back(8'hC3);
    m_bit(1'b0, r);
    m_read8(d);
    e = exp_q.pop_front();
    vecs++; if (d !== e) begin errs++; $display("FAIL rd_byte1 got %h want %h", d, e); end
    m_bit(1'b1, r);
    vecs++; if (bus.State !== ST_WAIT_STOP) begin errs++; $display("FAIL rd_nack_state got %0d want %0d", bus.State, ST_WAIT_STOP); end
    vecs++; if (tx_cnt != tx0 + 2) begin errs++; $display("FAIL rd_txreq_cnt got %0d want %0d", tx_cnt - tx0, 2); end
    m_stop(); wait_q();
    vecs++; if (bus.State !== ST_IDLE) begin errs++; $display("FAIL rd_idle got %0d want %0d", bus.State, ST_IDLE); end
  endtask

  task automatic test_mismatch();
    logic ack; int rx0, s0;
    rx0 = rx_cnt; s0 = slave_low_cnt;
    m_start();
    m_addr(OTHER_ADDR, 1'b1, ack);
    vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL mm_addr_nack got %b want 1", ack); end
    vecs++; if (bus.State !== ST_WAIT_STOP) begin errs++; $display("FAIL mm_state got %0d want %0d", bus.State, ST_WAIT_STOP); end
    m_write_byte(8'h00, ack);
    vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL mm_data_nack got %b want 1", ack); end
    vecs++; if (slave_low_cnt != s0) begin errs++; $display("FAIL mm_sda_driven got %0d want 0", slave_low_cnt - s0); end
    vecs++; if (rx_cnt != rx0) begin errs++; $display("FAIL mm_rxvalid got %0d want 0", rx_cnt - rx0); end
    vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL mm_busy got %b want 0", bus.Busy); end
    m_stop(); wait_q();
  endtask

  task automatic test_back_to_back();
    logic ack; logic [7:0] e; int rx0;
    logic [7:0] bytes [2];
    bytes[0] = 8'h5A; bytes[1] = 8'hC3;
    rx0 = rx_cnt;
    m_start();
    m_addr(MY_ADDR, 1'b1, ack);
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL b2b_addr_ack got %b want 0", ack); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(bytes[i]);
      m_write_byte(bytes[i], ack);
      vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL b2b_ack%0d got %b want 0", i, ack); end
      e = exp_q.pop_front();
      vecs++; if (last_rx !== e) begin errs++; $display("FAIL b2b_rxdata%0d got %h want %h", i, last_rx, e); end
    end
    vecs++; if (rx_cnt != rx0 + 2) begin errs++; $display("FAIL b2b_rxvalid_cnt got %0d want 2", rx_cnt - rx0); end
    m_stop(); wait_q();
    last_written = 8'hC3;
  endtask

  task automatic test_repeated_start();
    logic ack, r; logic [7:0] d, e;
    m_start();
    m_addr(MY_ADDR, 1'b1, ack);
    exp_q.push_back(8'h11);
    m_write_byte(8'h11, ack);
    e = exp_q.pop_front();
    vecs++; if (last_rx !== e) begin errs++; $display("FAIL rs_rxdata got %h want %h", last_rx, e); end
    bus.TxData = 8'h96; exp_q.push_back(8'h96);
    m_start();
    vecs++; if (bus.State !== ST_ADDR) begin errs++; $display("FAIL rs_state got %0d want %0d", bus.State, ST_ADDR); end
    vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL rs_busy got %b want 0", bus.Busy); end
    m_addr(MY_ADDR, 1'b0, ack);
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL rs_addr_ack got %b want 0", ack); end
    m_read8(d);
    e = exp_q.pop_front();
    vecs++; if (d !== e) begin errs++; $display("FAIL rs_read got %h want %h", d, e); end
    m_bit(1'b1, r);
    m_stop(); wait_q();
    vecs++; if (bus.RxData !== 8'h11) begin errs++; $display("FAIL rs_rxhold got %h want 11", bus.RxData); end
    last_written = 8'h11;
  endtask

  task automatic test_stop_mid_byte();
    logic ack, r; logic [7:0] d; int rx0;
    d = 8'h0F;
    m_start();
    m_addr(MY_ADDR, 1'b1, ack);
    rx0 = rx_cnt;
    for (int i = 0; i < 4; i++) m_bit(d[i], r);
    m_stop(); wait_q();
    vecs++; if (bus.State !== ST_IDLE) begin errs++; $display("FAIL smb_state got %0d want %0d", bus.State, ST_IDLE); end
    vecs++; if (rx_cnt != rx0) begin errs++; $display("FAIL smb_rxvalid got %0d want 0", rx_cnt - rx0); end
    vecs++; if (bus.RxData !== last_written) begin errs++; $display("FAIL smb_rxdata got %h want %h", bus.RxData, last_written); end
    vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL smb_busy got %b want 0", bus.Busy); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack, r; logic [7:0] e; int s0;
    m_start();
    for (int i = 0; i < 7; i++) m_bit(MY_ADDR[i], r);
    m_bit(1'b1, r);
    m_low = 1'b0; wait_q();
    vecs++; if (sda_line !== 1'b0) begin errs++; $display("FAIL rma_acking got %b want 0", sda_line); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if (sda_line !== 1'b1) begin errs++; $display("FAIL rma_sda_release got %b want 1", sda_line); end
    vecs++; if (bus.State !== ST_IDLE) begin errs++; $display("FAIL rma_state got %0d want %0d", bus.State, ST_IDLE); end
    @(negedge clk); rst = 1'b1;
    wait_q(); bus.Scl = 1'b1; wait_q(); wait_q(); bus.Scl = 1'b0; wait_q();
    s0 = slave_low_cnt;
    m_write_byte(8'h5A, ack);
    vecs++; if (ack !== 1'b1) begin errs++; $display("FAIL rma_ignore_ack got %b want 1", ack); end
    vecs++; if (slave_low_cnt != s0) begin errs++; $display("FAIL rma_sda_driven got %0d want 0", slave_low_cnt - s0); end
    vecs++; if (bus.State !== ST_IDLE) begin errs++; $display("FAIL rma_still_idle got %0d want %0d", bus.State, ST_IDLE); end
    m_stop(); wait_q();
    m_start();
    m_addr(MY_ADDR, 1'b1, ack);
    vecs++; if (ack !== 1'b0) begin errs++; $display("FAIL rma_new_ack got %b want 0", ack); end
    exp_q.push_back(8'h77);
    m_write_byte(8'h77, ack);
    e = exp_q.pop_front();
    vecs++; if (last_rx !== e) begin errs++; $display("FAIL rma_new_rxdata got %h want %h", last_rx, e); end
    m_stop(); wait_q();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_back_to_back();
    test_repeated_start();
    test_stop_mid_byte();
    test_reset_mid_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter ADDRESSLENGTH, default 7: number of slave address bits per transfer.
REQ-002 Parameter SLAVE_ADDR, default 7'h48: address this slave answers to, ADDRESSLENGTH bits wide.
REQ-003 Clk  input  1: single system clock; all logic on posedge Clk; at least 8x SCL frequency.
REQ-004 Rst  input  1: synchronous, active-low reset.
REQ-005 Scl  input  1: I2C clock from master, asynchronous to Clk.
REQ-006 Sda  inout  1: I2C data, open-drain; driven only to 0, otherwise 1'bz.
REQ-007 TxData  input  8: byte returned to master on reads; sampled when TxReq pulses.
REQ-008 TxReq  output  1: one-Clk pulse when TxData is loaded into the transmit shifter.
REQ-009 RxData  output  8: last byte written by master; held until the next byte completes.
REQ-010 RxValid  output  1: one-Clk pulse when RxData updates.
REQ-011 Busy  output  1: high from address match until STOP, START or reset.
REQ-012 State  output  4: current FSM state encoding, for debug.

Function
REQ-013 Scl and Sda SHALL each pass through a 2-flop synchronizer; edges SHALL be detected against a third registered copy.
REQ-014 START = synced Sda falling while synced Scl high; STOP = synced Sda rising while synced Scl high.
REQ-015 Bits SHALL be sampled on synced Scl rising and driven on synced Scl falling.
REQ-016 Bit order SHALL be LSB first for address and data. The R/W bit SHALL follow the address: 1 = master writes, 0 = master reads.
REQ-017 States: IDLE=0, ADDR=1, ADDR_ACK=2, RX_DATA=3, RX_ACK=4, TX_DATA=5, TX_ACK=6, WAIT_STOP=7.
REQ-018 IDLE -> ADDR on START. Bit counter and shifter SHALL clear.
REQ-019 ADDR SHALL sample ADDRESSLENGTH+1 bits.
- Address match: -> ADDR_ACK, Busy=1.
- Mismatch: -> WAIT_STOP, Sda never driven.
REQ-020 ADDR_ACK:
- Sda SHALL drive 0 from the Scl falling edge after the R/W bit until the next Scl falling edge.
- R/W=1: -> RX_DATA.
- R/W=0: -> TX_DATA.
REQ-021 RX_DATA SHALL shift 8 bits.
- After the 8th sample: RxData updated, RxValid pulsed one Clk later, -> RX_ACK.
REQ-022 RX_ACK SHALL drive Sda 0 for one SCL bit period (falling to falling), then -> RX_DATA.
- Every byte SHALL be acked; no byte-count limit.
REQ-023 On the Scl falling edge entering TX_DATA:
- TxData loaded, TxReq pulsed.
- bit0 driven (Sda driven 0 when the bit is 0, released when 1).
REQ-024 TX_DATA: each subsequent falling edge drives the next bit.
- After the 8th bit's falling edge: Sda released, -> TX_ACK.
REQ-025 TX_ACK SHALL sample Sda on Scl rising.
- 0 (ACK): next falling edge reloads TxData, pulses TxReq, -> TX_DATA.
- 1 (NACK): -> WAIT_STOP.
REQ-026 WAIT_STOP SHALL keep Sda released and ignore bits until STOP or START.
REQ-027 STOP in any state SHALL force IDLE, release Sda and clear Busy on the next Clk.
REQ-028 START in any non-IDLE state (repeated start) SHALL force ADDR, clear counter, release Sda and clear Busy.
REQ-029 When START/STOP coincides with a bit edge, START/STOP SHALL win.
REQ-030 No clock stretching: Scl SHALL never be driven.

Reset
REQ-031 While Rst=0 at posedge Clk:
- State=IDLE, Sda released, RxData=8'h00, RxValid=0, TxReq=0, Busy=0.
- Synchronizer flops = 1, counters = 0.
REQ-032 Reset mid-transfer SHALL release Sda on the same Clk edge.
- After reset, the slave SHALL ignore the bus until the next START.

Verification
REQ-033 Write, matching address: START, addr 0x48 + R/W=1, byte 0xA5, STOP -> ACK on addr and data; RxData=0xA5; one RxValid pulse; Busy 1->0 at STOP.
REQ-034 Read: START, addr 0x48 + R/W=0, TxData=0x3C, master ACK, TxData=0xC3, master NACK, STOP.
- Bus carries 0x3C then 0xC3, LSB first.
- Two TxReq pulses.
- -> WAIT_STOP then IDLE.
REQ-035 Mismatch: START, addr 0x21 -> Sda never driven low by slave, State=WAIT_STOP, no RxValid.
REQ-036 Repeated start: write byte 0x11, START, addr 0x48 read -> RxData=0x11; State passes ADDR; read proceeds normally.
REQ-037 Reset mid-ack: Rst=0 while driving ADDR_ACK -> Sda released same edge; State=IDLE; no response until new START.
REQ-038 STOP mid-byte: STOP after 4 of 8 write bits -> IDLE, RxData unchanged, no RxValid.
